bcd_div_checker_serial: RTL

//  Serial, parametrised successor to the 4-digit parallel BCD divisibility checker.

---
 rtl/bcd_div_checker_serial.sv | 95 +++++++++
 1 files changed

// File: rtl/bcd_div_checker_serial.sv
// bcd_div_checker_serial: serial BCD divisibility checker (3, 9, 11), one digit per handshake, MSD first.
module bcd_div_checker_serial #(
   parameter int NUM_DIGITS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] digit,
   input  logic       digit_valid,
   output logic       digit_ready,
   output logic       busy,
   output logic       done,
   output logic       div3,
   output logic       div9,
   output logic       div11,
   output logic       bcd_err
);
   localparam int CW = $clog2(NUM_DIGITS + 1);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [1:0] r3_q, r3_d;
   logic [3:0] r9_q, r9_d, r11_q, r11_d;
   logic div3_q, div3_d, div9_q, div9_d, div11_q, div11_d, bcd_err_q, bcd_err_d;
   logic [4:0] s9, s11;
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      r3_d      = r3_q;
      r9_d      = r9_q;
      r11_d     = r11_q;
      div3_d    = div3_q;
      div9_d    = div9_q;
      div11_d   = div11_q;
      bcd_err_d = bcd_err_q;
      s9        = {1'b0, r9_q} + {1'b0, digit};
      s11       = {1'b0, digit} + 5'd11 - {1'b0, r11_q};
      if (state_q == DONE) begin
         state_d = IDLE;
      end else if (start) begin
         state_d   = ACCUM;
         count_d   = '0;
         r3_d      = '0;
         r9_d      = '0;
         r11_d     = '0;
         div3_d    = 1'b0;
         div9_d    = 1'b0;
         div11_d   = 1'b0;
         bcd_err_d = 1'b0;
      end else if (state_q == ACCUM && digit_valid) begin
         r9_d      = 4'(s9 >= 5'd9 ? s9 - 5'd9 : s9);
         r11_d     = 4'(s11 >= 5'd11 ? s11 - 5'd11 : s11);
         // 3 divides 9, so the mod-3 remainder follows directly from the mod-9 one
         r3_d      = 2'(r9_d >= 4'd6 ? r9_d - 4'd6 : r9_d >= 4'd3 ? r9_d - 4'd3 : r9_d);
         bcd_err_d = bcd_err_q | (digit > 4'd9);
         count_d   = count_q + 1'b1;
         if (count_q == CW'(NUM_DIGITS - 1)) begin
            state_d = DONE;
            div3_d  = (r3_d == '0) && !bcd_err_d;
            div9_d  = (r9_d == '0) && !bcd_err_d;
            div11_d = (r11_d == '0) && !bcd_err_d;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         count_q   <= '0;
         r3_q      <= '0;
         r9_q      <= '0;
         r11_q     <= '0;
         div3_q    <= 1'b0;
         div9_q    <= 1'b0;
         div11_q   <= 1'b0;
         bcd_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         r3_q      <= r3_d;
         r9_q      <= r9_d;
         r11_q     <= r11_d;
         div3_q    <= div3_d;
         div9_q    <= div9_d;
         div11_q   <= div11_d;
         bcd_err_q <= bcd_err_d;
      end
   end
   assign digit_ready = state_q == ACCUM;
   assign busy        = state_q == ACCUM;
   assign done        = state_q == DONE;
   assign div3        = div3_q;
   assign div9        = div9_q;
   assign div11       = div11_q;
   assign bcd_err     = bcd_err_q;
endmodule
